// File: rtl/program_loader.sv
// program_loader: boot-time loader that streams a framed program image
// (header word, N data words) into the shared memory write port and holds
// the cpu in reset until the image is complete.
// Header word: [15:8] must equal MAGIC, [7:0] is the data word count N.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing checksum
// word (sum of the data words mod 2^16) and the CHECK state that verifies it.
module program_loader #(
  parameter int                 ADDR_W    = 8,
  parameter int                 DATA_W    = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [7:0]         MAGIC     = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              cpu_reset_out,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [ADDR_W:0] r_len;
  logic            w_accept;
  logic            w_last;
  logic            w_hdr_ok;
  logic [7:0]      w_len;
  logic [31:0]     w_end;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
`endif

  assign w_accept = in_valid && in_ready;
  assign w_len    = in_data[7:0];
  // One past the last address the image would touch; must not exceed memory.
  assign w_end    = 32'(BASE_ADDR) + 32'(w_len);
  assign w_hdr_ok = (in_data[15:8] == MAGIC) && (w_len != 8'd0) &&
                    (w_end <= (32'd1 << ADDR_W));
  assign w_last   = (word_count == r_len - (ADDR_W+1)'(1));

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments for every clocked register, so all
    // flops sample the pre-edge values regardless of block ordering.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: header decode, last-word detect, checksum compare.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = w_hdr_ok ? S_LOAD : S_ERROR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_LOAD:  if (w_accept && w_last) w_next = S_CHECK;
      S_CHECK: if (w_accept) w_next = (in_data == r_sum) ? S_RUN : S_ERROR;
`else
      S_LOAD:  if (w_accept && w_last) w_next = S_DRAIN;
`endif
      S_DRAIN: w_next = S_RUN;
      S_RUN:   w_next = S_RUN;
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_ERROR;
    endcase
  end

  // Control outputs decoded directly from the current state.
  always_comb begin
    in_ready      = 1'b0;
    cpu_reset_out = 1'b1;
    load_done     = 1'b0;
    load_error    = 1'b0;
    unique case (r_state)
      S_IDLE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_LOAD:  in_ready = 1'b1;
      S_RUN: begin
        cpu_reset_out = 1'b0;
        load_done     = 1'b1;
      end
      S_ERROR: load_error = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Write datapath: register each accepted data word into a one-cycle strobe;
  // address and data hold between strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      word_count       <= '0;
      r_len            <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_sum            <= '0;
`endif
    end else begin
      mem_write_enable <= (r_state == S_LOAD) && w_accept;
      if ((r_state == S_IDLE) && w_accept) r_len <= (ADDR_W+1)'(w_len);
      if ((r_state == S_LOAD) && w_accept) begin
        // Header length check guarantees this sum never wraps.
        mem_address    <= BASE_ADDR + word_count[ADDR_W-1:0];
        mem_write_data <= in_data;
        word_count     <= word_count + (ADDR_W+1)'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        r_sum          <= r_sum + in_data;
`endif
      end
    end
  end

endmodule
